// File: rtl/pipelined_adder_pkg.sv
// Shared definitions for the segmented pipelined adder: segment sizing,
// parameter legality check and add/sub mode encodings.
`ifndef PIPELINED_ADDER_PKG_SV
`define PIPELINED_ADDER_PKG_SV

// Elaboration-time guard: STAGES must lie in 1..N and divide N evenly.
`define PA_ASSERT_DIV(n, s) \
  if ((s) < 1 || (s) > (n) || ((n) % (s)) != 0) begin : g_div_chk \
    $error("pipelined_adder: N must be a multiple of STAGES, 1 <= STAGES <= N"); \
  end

package pipelined_adder_pkg;
  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int seg_width(input int n, input int stages);
    return n / stages;
  endfunction
endpackage

`endif

// File: rtl/pipelined_adder_if.sv
// Operand/result bundle for pipelined_adder; master drives operands,
// slave (the adder) returns the registered result.
interface pipelined_adder_if #(
  parameter int N = 16
);
  logic         i_valid;
  logic         i_stall;
  logic         i_sub;
  logic         i_carry;
  logic [N-1:0] i_sampleA;
  logic [N-1:0] i_sampleB;
  logic         o_valid;
  logic [N:0]   o_sum;
  logic         o_overflow;

  modport master (
    output i_valid, i_stall, i_sub, i_carry, i_sampleA, i_sampleB,
    input  o_valid, o_sum, o_overflow
  );

  modport slave (
    input  i_valid, i_stall, i_sub, i_carry, i_sampleA, i_sampleB,
    output o_valid, o_sum, o_overflow
  );
endinterface

// File: rtl/pipelined_adder_stage.sv
// One SEG-bit carry segment with its sum/carry/valid registers and hold enable.
// Only the top segment registers a meaningful overflow flag.
module pipe_adder_stage #(
  parameter int SEG  = 4,
  parameter bit LAST = 1'b0
) (
  input  logic           clock,
  input  logic           i_reset,
  input  logic           i_en,
  input  logic           i_ld,
  input  logic           i_vld,
  input  logic [SEG-1:0] i_a,
  input  logic [SEG-1:0] i_b,
  input  logic           i_cin,
  output logic [SEG-1:0] o_sum,
  output logic           o_cout,
  output logic           o_ovf,
  output logic           o_vld
);
  logic [SEG:0]   w_full;
  logic           w_cmsb;
  logic [SEG-1:0] r_sum;
  logic           r_cout;
  logic           r_ovf;
  logic           r_vld;

  assign w_full = {1'b0, i_a} + {1'b0, i_b} + {{SEG{1'b0}}, i_cin};
  // carry into the MSB recovered from the MSB sum bit
  assign w_cmsb = w_full[SEG-1] ^ i_a[SEG-1] ^ i_b[SEG-1];

  always_ff @(posedge clock) begin
    if (i_reset) begin
      r_sum  <= '0;
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_vld  <= 1'b0;
    end else if (i_en) begin
      r_vld <= i_vld;
      if (i_ld) begin
        r_sum  <= w_full[SEG-1:0];
        r_cout <= w_full[SEG];
        r_ovf  <= LAST ? (w_full[SEG] ^ w_cmsb) : 1'b0;
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;
  assign o_vld  = r_vld;
endmodule

// File: rtl/pipelined_adder.sv
// N-bit add/sub with carry chain split over STAGES registered segments.
// Operands are skewed into their stage, sums deskewed so all bits emerge together.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int N      = 16,
  parameter int STAGES = 4
) (
  input  logic             clock,
  input  logic             i_reset,
  pipelined_adder_if.slave bus
);
  localparam int SEG = seg_width(N, STAGES);

  `PA_ASSERT_DIV(N, STAGES)

  logic [N-1:0]    w_b_cond;
  logic [STAGES:0] w_vld_pipe;
  logic [STAGES:0] w_carry;
  logic [STAGES-1:0] w_ovf;
  logic [N-1:0]    w_sum_flat;
  logic [SEG-1:0]  w_a_stg   [STAGES];
  logic [SEG-1:0]  w_b_stg   [STAGES];
  logic [SEG-1:0]  w_sum_stg [STAGES];
  logic            w_ld_out;

  assign w_b_cond      = (bus.i_sub == MODE_SUB) ? ~bus.i_sampleB : bus.i_sampleB;
  assign w_carry[0]    = (bus.i_sub == MODE_SUB) ? ~bus.i_carry : bus.i_carry;
  assign w_vld_pipe[0] = bus.i_valid;
  // output-side registers only capture when a real result arrives, so bubbles hold o_sum
  assign w_ld_out      = w_vld_pipe[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    if (k == 0) begin : g_noskew
      assign w_a_stg[k] = bus.i_sampleA[SEG-1:0];
      assign w_b_stg[k] = w_b_cond[SEG-1:0];
    end else begin : g_skew
      logic [SEG-1:0] r_a [k];
      logic [SEG-1:0] r_b [k];
      always_ff @(posedge clock) begin
        if (i_reset) begin
          for (int i = 0; i < k; i++) begin
            r_a[i] <= '0;
            r_b[i] <= '0;
          end
        end else if (!bus.i_stall) begin
          r_a[0] <= bus.i_sampleA[k*SEG +: SEG];
          r_b[0] <= w_b_cond[k*SEG +: SEG];
          for (int i = 1; i < k; i++) begin
            r_a[i] <= r_a[i-1];
            r_b[i] <= r_b[i-1];
          end
        end
      end
      assign w_a_stg[k] = r_a[k-1];
      assign w_b_stg[k] = r_b[k-1];
    end

    pipe_adder_stage #(
      .SEG  (SEG),
      .LAST (k == STAGES-1)
    ) u_stage (
      .clock   (clock),
      .i_reset (i_reset),
      .i_en    (!bus.i_stall),
      .i_ld    ((k == STAGES-1) ? w_ld_out : 1'b1),
      .i_vld   (w_vld_pipe[k]),
      .i_a     (w_a_stg[k]),
      .i_b     (w_b_stg[k]),
      .i_cin   (w_carry[k]),
      .o_sum   (w_sum_stg[k]),
      .o_cout  (w_carry[k+1]),
      .o_ovf   (w_ovf[k]),
      .o_vld   (w_vld_pipe[k+1])
    );

    if (k < STAGES-1) begin : g_deskew
      localparam int D = STAGES-1-k;
      logic [SEG-1:0] r_d [D];
      always_ff @(posedge clock) begin
        if (i_reset) begin
          for (int i = 0; i < D; i++) r_d[i] <= '0;
        end else if (!bus.i_stall) begin
          if (D > 1 || w_ld_out) r_d[0] <= w_sum_stg[k];
          for (int i = 1; i < D; i++)
            if (i < D-1 || w_ld_out) r_d[i] <= r_d[i-1];
        end
      end
      assign w_sum_flat[k*SEG +: SEG] = r_d[D-1];
    end else begin : g_top
      assign w_sum_flat[k*SEG +: SEG] = w_sum_stg[k];
    end
  end

  assign bus.o_valid    = w_vld_pipe[STAGES];
  assign bus.o_sum      = {w_carry[STAGES], w_sum_flat};
  assign bus.o_overflow = |w_ovf;
endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench: STAGES=4 main instance plus STAGES=1 and STAGES=16 instances
// sharing the same stimulus for the reset/latency checks.
module tb_pipelined_adder;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         d_rst, d_valid, d_stall, d_sub, d_carry;
  logic [N-1:0] d_a, d_b;
  int           n_chk  = 0;
  int           n_fail = 0;

  pipelined_adder_if #(.N(N)) bus4  ();
  pipelined_adder_if #(.N(N)) bus1  ();
  pipelined_adder_if #(.N(N)) bus16 ();

  assign {bus4.i_valid, bus4.i_stall, bus4.i_sub, bus4.i_carry, bus4.i_sampleA, bus4.i_sampleB}
    = {d_valid, d_stall, d_sub, d_carry, d_a, d_b};
  assign {bus1.i_valid, bus1.i_stall, bus1.i_sub, bus1.i_carry, bus1.i_sampleA, bus1.i_sampleB}
    = {d_valid, d_stall, d_sub, d_carry, d_a, d_b};
  assign {bus16.i_valid, bus16.i_stall, bus16.i_sub, bus16.i_carry, bus16.i_sampleA, bus16.i_sampleB}
    = {d_valid, d_stall, d_sub, d_carry, d_a, d_b};

  pipelined_adder #(.N(N), .STAGES(4))  u_dut4  (.clock(clk), .i_reset(d_rst), .bus(bus4));
  pipelined_adder #(.N(N), .STAGES(1))  u_dut1  (.clock(clk), .i_reset(d_rst), .bus(bus1));
  pipelined_adder #(.N(N), .STAGES(16)) u_dut16 (.clock(clk), .i_reset(d_rst), .bus(bus16));

  // index 0: STAGES=4, 1: STAGES=1, 2: STAGES=16
  logic        o_v [3];
  logic [N:0]  o_s [3];
  logic        o_f [3];
  int          lat [3] = '{4, 1, 16};

  assign o_v[0] = bus4.o_valid;  assign o_s[0] = bus4.o_sum;  assign o_f[0] = bus4.o_overflow;
  assign o_v[1] = bus1.o_valid;  assign o_s[1] = bus1.o_sum;  assign o_f[1] = bus1.o_overflow;
  assign o_v[2] = bus16.o_valid; assign o_s[2] = bus16.o_sum; assign o_f[2] = bus16.o_overflow;

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic c, input logic s);
    d_valid = v; d_a = a; d_b = b; d_carry = c; d_sub = s;
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // full result check on one instance
  task automatic chk_out(input string tag, input int i, input logic v,
                         input logic [N:0] s, input logic f);
    chk({tag, "_valid"}, {31'd0, o_v[i]}, {31'd0, v});
    chk({tag, "_sum"},   {15'd0, o_s[i]}, {15'd0, s});
    chk({tag, "_ovf"},   {31'd0, o_f[i]}, {31'd0, f});
  endtask

  initial begin
    d_rst = 1'b1; d_stall = 1'b0;
    idle();
    tick(); tick();
    for (int i = 0; i < 3; i++) chk_out($sformatf("reset_d%0d", i), i, 1'b0, 17'h00000, 1'b0);
    d_rst = 1'b0;

    // full carry ripple, latency of 4 edges
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    chk("ripple_early_valid", {31'd0, o_v[0]}, 32'd0);
    tick(); chk_out("ripple", 0, 1'b1, 17'h10000, 1'b0);
    tick(); chk_out("ripple_bubble", 0, 1'b0, 17'h10000, 1'b0);

    // back-to-back streaming
    drive(1'b1, 16'h1234, 16'h1111, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h8000, 16'h8000, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h00FF, 16'h0001, 1'b1, 1'b0); tick();
    idle(); tick();
    chk_out("stream0", 0, 1'b1, 17'h02345, 1'b0); tick();
    chk_out("stream1", 0, 1'b1, 17'h10000, 1'b1); tick();
    chk_out("stream2", 0, 1'b1, 17'h00101, 1'b0); tick();
    chk_out("stream_bubble", 0, 1'b0, 17'h00101, 1'b0);

    // subtract with borrow-in
    drive(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1); tick();
    drive(1'b1, 16'h0007, 16'h0005, 1'b1, 1'b1); tick();
    idle(); tick();
    chk("sub_early_valid", {31'd0, o_v[0]}, 32'd0); tick();
    chk_out("sub_borrow", 0, 1'b1, 17'h0FFFE, 1'b0); tick();
    chk_out("sub_noborrow", 0, 1'b1, 17'h10001, 1'b0);

    // signed overflow, add then sub
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); tick();
    drive(1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1); tick();
    idle(); tick(); tick();
    chk_out("ovf_add", 0, 1'b1, 17'h08000, 1'b1); tick();
    chk_out("ovf_sub", 0, 1'b1, 17'h17FFF, 1'b1); tick();

    // stall mid-flight; a valid presented during the stall must be ignored
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
    idle(); tick(); tick();
    chk_out("stall_pre", 0, 1'b0, 17'h17FFF, 1'b1);
    d_stall = 1'b1;
    drive(1'b1, 16'h0001, 16'h0001, 1'b0, 1'b0);
    tick(); chk_out("stall_hold1", 0, 1'b0, 17'h17FFF, 1'b1);
    tick(); chk_out("stall_hold2", 0, 1'b0, 17'h17FFF, 1'b1);
    d_stall = 1'b0; idle();
    tick(); chk_out("stall_result", 0, 1'b1, 17'h10000, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(); chk($sformatf("stall_noleak%0d", k), {31'd0, o_v[0]}, 32'd0);
    end

    for (int k = 0; k < 20; k++) tick();

    // reset mid-operation on all three depths
    drive(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0); tick();
    chk_out("rst_op1_d1", 1, 1'b1, 17'h10000, 1'b0);
    chk("rst_op1_d0_valid", {31'd0, o_v[0]}, 32'd0);
    chk("rst_op1_d2_valid", {31'd0, o_v[2]}, 32'd0);
    drive(1'b1, 16'h00AA, 16'h0055, 1'b0, 1'b0); tick();
    chk_out("rst_op2_d1", 1, 1'b1, 17'h000FF, 1'b0);
    drive(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0); d_rst = 1'b1; tick();
    for (int i = 0; i < 3; i++) chk_out($sformatf("rst_clear_d%0d", i), i, 1'b0, 17'h00000, 1'b0);
    d_rst = 1'b0; idle();
    for (int k = 0; k < 20; k++) begin
      tick();
      for (int i = 0; i < 3; i++)
        chk($sformatf("rst_nostale_d%0d_c%0d", i, k), {31'd0, o_v[i]}, 32'd0);
    end

    // post-reset op with each instance's own latency
    drive(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b0); tick();
    idle();
    for (int k = 0; k < 18; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (k == lat[i] - 1)
          chk_out($sformatf("post_rst_d%0d", i), i, 1'b1, 17'h05555, 1'b0);
        else
          chk($sformatf("post_rst_d%0d_c%0d", i, k), {31'd0, o_v[i]}, 32'd0);
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
